// File: rtl/imm_gen_pkg.sv
// Shared opcode and immediate-format definitions for the registered immediate generator.
// The CSR zimm format (FMT_Z) is only produced when IMM_GEN_CSR_EN is defined.
package imm_gen_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational immediate decoder: maps a raw instruction word to a sign-extended immediate
// and its format code. CSR zimm decoding is enabled by defining IMM_GEN_CSR_EN.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt
);

    // Every format fits in 32 bits; widening to XLEN is a single sign extension of bit 31.
    logic signed [31:0] raw;

    always_comb begin
        raw = '0;
        fmt = FMT_NONE;
        case (opcode_of(instr))
            OP_IMM, LOAD, JALR: begin
                raw = {{20{instr[31]}}, instr[31:20]};
                fmt = FMT_I;
            end
            STORE: begin
                raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt = FMT_S;
            end
            BRANCH: begin
                raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt = FMT_B;
            end
            LUI, AUIPC: begin
                raw = {instr[31:12], 12'b0};
                fmt = FMT_U;
            end
            JAL: begin
                raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt = FMT_J;
            end
`ifdef IMM_GEN_CSR_EN
            SYSTEM: begin
                if (instr[14]) begin
                    raw = {27'b0, instr[19:15]};
                    fmt = FMT_Z;
                end
            end
`endif
            default: begin
                raw = '0;
                fmt = FMT_NONE;
            end
        endcase
    end

    assign imm = XLEN'(raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry (output + skid) valid/ready buffer, flush and tag.
// Build with IMM_GEN_CSR_EN defined to decode the CSR zimm format.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    entry_t          dec_entry;

    entry_t or_q, or_d, sk_q, sk_d;
    logic   or_valid_q, or_valid_d, sk_valid_q, sk_valid_d;
    logic   accept, drain;

    imm_gen_decode #(.XLEN(XLEN)) u_decode (
        .instr (instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, tag: in_tag};
    assign accept    = in_valid & ~sk_valid_q;
    assign drain     = or_valid_q & out_ready;

    // The output register only changes when empty or draining, which keeps a stalled output stable.
    always_comb begin
        or_d       = or_q;
        sk_d       = sk_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else if (!or_valid_q || drain) begin
            if (sk_valid_q) begin
                or_d       = sk_q;
                or_valid_d = 1'b1;
                sk_valid_d = 1'b0;
            end else if (accept) begin
                or_d       = dec_entry;
                or_valid_d = 1'b1;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            sk_d       = dec_entry;
            sk_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q       <= '0;
            sk_q       <= '0;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
        end
    end

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready  = ~sk_valid_q;
    assign out_valid = or_valid_q;
    assign imm       = or_q.imm;
    assign fmt       = or_q.fmt;
    assign out_tag   = or_q.tag;

endmodule
